// File: rtl/data_memory_ctrl.sv
// Load/store data memory controller: byte/half/word access with read-modify-write.
// Optional macro DMEM_MISALIGN_TRAP_EN reports misaligned accesses via resp_err.
module data_memory_ctrl #(
    parameter int ADDR_WORDS_LOG2 = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr_en,
    input  logic [1:0]  req_size_sel,
    input  logic        req_zero_extend,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int AW = ADDR_WORDS_LOG2 + 2;
    localparam int DEPTH = 1 << ADDR_WORDS_LOG2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]    state;
    logic          wr_en_q;
    logic [1:0]    size_q;
    logic          zext_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rd_word_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] eff_addr;
    logic          misal;
    logic [ADDR_WORDS_LOG2-1:0] idx;
    logic [31:0]   rd_word;
    logic [31:0]   shifted;
    logic [31:0]   ld_data;
    logic [4:0]    sh;
    logic [31:0]   mask;
    logic [31:0]   lane_data;
    logic [31:0]   wr_word;
    logic          unused_addr;

    assign unused_addr = ^req_addr[31:AW];

    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misal = ((req_size_sel == 2'd1) && req_addr[0]) ||
                   (req_size_sel[1] && (req_addr[1:0] != 2'b00));
`else
    assign misal = 1'b0;
`endif

    // Aligning is harmless with the trap on: misaligned requests never touch the array.
    always_comb begin
        eff_addr = req_addr[AW-1:0];
        if (req_size_sel[1])
            eff_addr[1:0] = 2'b00;
        else if (req_size_sel == 2'd1)
            eff_addr[0] = 1'b0;
    end

    assign idx     = addr_q[AW-1:2];
    assign rd_word = mem[idx];
    assign sh      = {addr_q[1:0], 3'b000};
    assign shifted = rd_word >> sh;

    always_comb begin
        ld_data = rd_word;
        if (size_q == 2'd0)
            ld_data = zext_q ? {24'd0, shifted[7:0]}
                             : {{24{shifted[7]}}, shifted[7:0]};
        else if (size_q == 2'd1)
            ld_data = zext_q ? {16'd0, shifted[15:0]}
                             : {{16{shifted[15]}}, shifted[15:0]};
    end

    always_comb begin
        mask      = 32'hFFFF_FFFF;
        lane_data = wdata_q;
        if (size_q == 2'd0) begin
            mask      = 32'h0000_00FF << sh;
            lane_data = {4{wdata_q[7:0]}};
        end else if (size_q == 2'd1) begin
            mask      = 32'h0000_FFFF << sh;
            lane_data = {2{wdata_q[15:0]}};
        end
        wr_word = (rd_word_q & ~mask) | (lane_data & mask);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wr_en_q   <= 1'b0;
            size_q    <= 2'd0;
            zext_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            rd_word_q <= 32'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr_en_q <= req_wr_en;
                        size_q  <= req_size_sel;
                        zext_q  <= req_zero_extend;
                        addr_q  <= eff_addr;
                        wdata_q <= req_wdata;
                        err_q   <= misal;
                        rdata_q <= 32'd0;
                        if (misal)
                            state <= RESP;
                        else if (req_wr_en && req_size_sel[1])
                            state <= WR;
                        else
                            state <= RD;
                    end
                end
                RD: begin
                    rd_word_q <= rd_word;
                    if (wr_en_q) begin
                        state <= WR;
                    end else begin
                        rdata_q <= ld_data;
                        state   <= RESP;
                    end
                end
                WR: begin
                    rdata_q <= 32'd0;
                    state   <= RESP;
                end
                RESP: begin
                    if (resp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array has no reset; a reset drops state out of WR before any write edge.
    always_ff @(posedge clock) begin
        if (state == WR)
            mem[idx] <= wr_word;
    end

endmodule
